// File: rtl/lake_cfg_pkg.sv
// Shared types and helpers for the lake configuration loader.
package lake_cfg_pkg;

   localparam int unsigned DefaultWordWidth = 32;

   typedef enum logic [1:0] {
      StEmpty,
      StLoad,
      StReady,
      StActive
   } cfg_state_e;

   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/lake_cfg_addr_decode.sv
// Range check and one-hot word select for a configuration word index.
module lake_cfg_addr_decode #(
   parameter int unsigned NumWords = 16
) (
   input  logic [31:0]         addr_i,
   output logic                in_range_o,
   output logic [NumWords-1:0] sel_o
);

   always_comb begin
      in_range_o = (addr_i < NumWords);
      for (int i = 0; i < NumWords; i++) begin
         sel_o[i] = in_range_o && (addr_i == 32'(i));
      end
   end

endmodule

// File: rtl/lake_config_loader.sv
// Shadow/active configuration loader feeding lakespec config_memory.
// Optional readback path enabled by defining LAKE_CFG_READBACK_EN.
module lake_config_loader
   import lake_cfg_pkg::*;
#(
   parameter int unsigned CONFIG_MEMORY_SIZE = 512,
   parameter int unsigned WORD_WIDTH         = DefaultWordWidth
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   config_config_addr,
   input  logic [WORD_WIDTH-1:0]         config_config_data,
   input  logic                          config_write,
   input  logic                          config_read,
   input  logic                          config_commit,
   output logic [WORD_WIDTH-1:0]         config_rd_data,
   output logic                          config_rd_valid,
   output logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
   output logic                          config_valid,
   output logic                          config_err
);

   localparam int unsigned NumWords = ceil_div(CONFIG_MEMORY_SIZE, WORD_WIDTH);
   localparam int unsigned FlatBits = NumWords * WORD_WIDTH;
   localparam int unsigned PadBits  = FlatBits - CONFIG_MEMORY_SIZE;
   // Bits of the last word that fall beyond the configuration are never stored.
   localparam logic [WORD_WIDTH-1:0] LastMask = {WORD_WIDTH{1'b1}} >> PadBits;

   cfg_state_e state_q, state_d;

   logic [NumWords-1:0][WORD_WIDTH-1:0] shadow_q, shadow_d;
   logic [FlatBits-1:0]                 shadow_flat;
   logic [NumWords-1:0]                 bitmap_q, bitmap_d;
   logic [CONFIG_MEMORY_SIZE-1:0]       active_q;
   logic                                valid_q, err_q, err_d;
   logic                                wr_in_range, wr_ok;
   logic [NumWords-1:0]                 wr_sel;
   logic                                commit_ok, commit_err, rd_err;

   lake_cfg_addr_decode #(
      .NumWords (NumWords)
   ) u_wr_decode (
      .addr_i     (config_config_addr),
      .in_range_o (wr_in_range),
      .sel_o      (wr_sel)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   // A write in the commit cycle reopens the load with only that word marked.
   always_comb begin
      state_d = state_q;
      if (commit_ok && !wr_ok) begin
         state_d = StActive;
      end else if (wr_ok) begin
         state_d = (&bitmap_d) ? StReady : StLoad;
      end
   end

   always_comb begin
      commit_ok  = 1'b0;
      commit_err = 1'b0;
      case (state_q)
         StEmpty, StLoad: commit_err = config_commit;
         StReady:         commit_ok  = config_commit;
         default:         ;
      endcase
   end

   always_comb begin
      wr_ok    = config_write && wr_in_range;
      bitmap_d = commit_ok ? '0 : bitmap_q;
      if (wr_ok) begin
         bitmap_d = bitmap_d | wr_sel;
      end
      shadow_d = shadow_q;
      for (int i = 0; i < NumWords; i++) begin
         if (wr_ok && wr_sel[i]) begin
            shadow_d[i] = config_config_data & ((i == NumWords - 1) ? LastMask : '1);
         end
      end
      err_d = commit_err | (config_write && !wr_in_range) | rd_err;
   end

   assign shadow_flat = shadow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         bitmap_q <= '0;
         active_q <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         bitmap_q <= bitmap_d;
         err_q    <= err_d;
         if (commit_ok) begin
            active_q <= shadow_flat[CONFIG_MEMORY_SIZE-1:0];
            valid_q  <= 1'b1;
         end
      end
   end

`ifdef LAKE_CFG_READBACK_EN
   logic                  rd_in_range;
   logic [NumWords-1:0]   rd_sel;
   logic [WORD_WIDTH-1:0] rd_word, rd_data_q;
   logic                  rd_valid_q;

   lake_cfg_addr_decode #(
      .NumWords (NumWords)
   ) u_rd_decode (
      .addr_i     (config_config_addr),
      .in_range_o (rd_in_range),
      .sel_o      (rd_sel)
   );

   // Reads see shadow_q, so a same-cycle write to the same word is not yet visible.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NumWords; i++) begin
         if (rd_sel[i]) begin
            rd_word = rd_word | shadow_q[i];
         end
      end
   end

   assign rd_err = config_read && !rd_in_range;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= config_read;
         if (config_read) begin
            rd_data_q <= rd_word;
         end
      end
   end

   assign config_rd_data  = rd_data_q;
   assign config_rd_valid = rd_valid_q;
`else
   assign rd_err          = config_read & 1'b0;
   assign config_rd_data  = '0;
   assign config_rd_valid = 1'b0;
`endif

   assign config_memory = active_q;
   assign config_valid  = valid_q;
   assign config_err    = err_q;

endmodule

// File: tb/tb_lake_config_loader.sv
// Directed bench for lake_config_loader: default build plus a 500-bit instance
// driven by the same strobes to exercise the truncated last word.
module tb_lake_config_loader;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        write, read, commit;

   logic [31:0]  rd_data,  rd_data5;
   logic         rd_valid, rd_valid5;
   logic [511:0] mem;
   logic [499:0] mem5;
   logic         valid, valid5, err, err5;

   int n_checks = 0;
   int n_errors = 0;

   lake_config_loader u_dut (
      .clk                (clk),
      .rst                (rst),
      .config_config_addr (addr),
      .config_config_data (wdata),
      .config_write       (write),
      .config_read        (read),
      .config_commit      (commit),
      .config_rd_data     (rd_data),
      .config_rd_valid    (rd_valid),
      .config_memory      (mem),
      .config_valid       (valid),
      .config_err         (err)
   );

   lake_config_loader #(
      .CONFIG_MEMORY_SIZE (500)
   ) u_dut500 (
      .clk                (clk),
      .rst                (rst),
      .config_config_addr (addr),
      .config_config_data (wdata),
      .config_write       (write),
      .config_read        (read),
      .config_commit      (commit),
      .config_rd_data     (rd_data5),
      .config_rd_valid    (rd_valid5),
      .config_memory      (mem5),
      .config_valid       (valid5),
      .config_err         (err5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      write = 1'b1;
      step();
      write = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      addr = a;
      read = 1'b1;
      step();
      read = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      step();
      commit = 1'b0;
   endtask

   initial begin
      rst = 1'b1; addr = '0; wdata = '0; write = 1'b0; read = 1'b0; commit = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      check_eq("reset_mem", mem, '0);
      check_eq("reset_valid", valid, 1'b0);
      check_eq("reset_err", err, 1'b0);
      check_eq("reset_rd_valid", rd_valid, 1'b0);
      check_eq("reset_rd_data", rd_data, '0);

      // Incomplete load: commit rejected.
      for (int i = 0; i < 15; i++) wr(i, 32'h1000 + i);
      do_commit();
      check_eq("partial_commit_err", err, 1'b1);
      check_eq("partial_commit_valid", valid, 1'b0);
      check_eq("partial_commit_mem", mem, '0);
      step();
      check_eq("err_single_pulse", err, 1'b0);

      // Completing word 15 makes the image committable.
      wr(15, 32'h100F);
      check_eq("ready_not_valid", valid, 1'b0);
      do_commit();
      check_eq("commit_err", err, 1'b0);
      check_eq("commit_valid", valid, 1'b1);
      check_eq("commit_word0", mem[31:0], 32'h1000);
      check_eq("commit_word15", mem[511:480], 32'h100F);
      check_eq("commit500_word0", mem5[31:0], 32'h1000);
      check_eq("commit500_word15", mem5[499:480], 20'h0100F);

      do_commit();
      check_eq("active_commit_noerr", err, 1'b0);

      // Out-of-range write leaves state ACTIVE and the shadow intact.
      wr(16, 32'hDEAD);
      check_eq("oor_write_err", err, 1'b1);
      do_commit();
      check_eq("oor_write_state_kept", err, 1'b0);
      check_eq("oor_write_mem_kept", mem[31:0], 32'h1000);
`ifdef LAKE_CFG_READBACK_EN
      for (int i = 0; i < 16; i++) begin
         rd(i);
         check_eq("readback_after_oor", {rd_valid, rd_data}, {1'b1, 32'h1000 + i});
      end
`else
      rd(0);
      check_eq("no_readback_valid", rd_valid, 1'b0);
      check_eq("no_readback_data", rd_data, '0);
`endif

      // Reload, then commit with a same-cycle write to word 3.
      for (int i = 0; i < 16; i++) wr(i, (i == 5) ? 32'h5555 : 32'h1000 + i);
      check_eq("mem_stable_before_commit", mem[191:160], 32'h1005);
      addr = 3; wdata = 32'hBEEF; write = 1'b1; commit = 1'b1;
      step();
      write = 1'b0; commit = 1'b0;
      check_eq("wc_commit_err", err, 1'b0);
      check_eq("wc_word5_new", mem[191:160], 32'h5555);
      check_eq("wc_word3_old", mem[127:96], 32'h1003);
      do_commit();
      check_eq("wc_state_load", err, 1'b1);
      check_eq("wc_valid_kept", valid, 1'b1);
`ifdef LAKE_CFG_READBACK_EN
      rd(3);
      check_eq("wc_readback_word3", rd_data, 32'hBEEF);

      addr = 3; wdata = 32'h7777; write = 1'b1; read = 1'b1;
      step();
      write = 1'b0; read = 1'b0;
      check_eq("rw_same_cycle", {rd_valid, rd_data}, {1'b1, 32'hBEEF});
      rd(3);
      check_eq("rw_after", rd_data, 32'h7777);
      rd(20);
      check_eq("oor_read", {rd_valid, rd_data, err}, {1'b1, 32'h0, 1'b1});
`else
      rd(20);
      check_eq("oor_read_ignored", {rd_valid, err}, 2'b00);
`endif

      // Last-word truncation on the 500-bit instance.
      wr(15, 32'hFFFF_FFFF);
`ifdef LAKE_CFG_READBACK_EN
      rd(15);
      check_eq("pad_rd_512", rd_data, 32'hFFFF_FFFF);
      check_eq("pad_rd_500", rd_data5, 32'h000F_FFFF);
`endif

      // Reset mid-load; strobes in the reset cycle are ignored.
      for (int i = 0; i < 8; i++) wr(i, 32'hA0 + i);
      rst = 1'b1; addr = 8; wdata = 32'h1234; write = 1'b1; commit = 1'b1;
      step();
      rst = 1'b0; write = 1'b0; commit = 1'b0;
      check_eq("rst_mem", mem, '0);
      check_eq("rst_mem500", mem5, '0);
      check_eq("rst_flags", {valid, err, rd_valid}, 3'b000);
      check_eq("rst_rd_data", rd_data, '0);
      do_commit();
      check_eq("rst_commit_err", err, 1'b1);
      check_eq("rst_commit_valid", valid, 1'b0);
`ifdef LAKE_CFG_READBACK_EN
      rd(0);
      check_eq("rst_shadow_cleared", rd_data, '0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lake_config_loader.md
LAKE_CONFIG_LOADER -- requirements
Module: lake_config_loader

Interface
REQ-001 Parameter CONFIG_MEMORY_SIZE, default 512: width in bits of the flat configuration delivered to lakespec.
REQ-002 Parameter WORD_WIDTH, default 32: width of one configuration bus word.
REQ-003 Derived NUM_WORDS = ceil(CONFIG_MEMORY_SIZE/WORD_WIDTH); default 16.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 config_config_addr  input  32  word index of the configuration access.
REQ-007 config_config_data  input  WORD_WIDTH  write data.
REQ-008 config_write  input  1  write strobe, one word per cycle.
REQ-009 config_read  input  1  read strobe.
REQ-010 config_commit  input  1  copy the shadow image to the active image.
REQ-011 config_rd_data  output  WORD_WIDTH  readback data.
REQ-012 config_rd_valid  output  1  qualifies config_rd_data.
REQ-013 config_memory  output  CONFIG_MEMORY_SIZE  active image, drives lakespec config_memory.
REQ-014 config_valid  output  1  active image holds a committed configuration.
REQ-015 config_err  output  1  single-cycle error pulse.

Function
REQ-016 Shadow image of NUM_WORDS words; write at addr a<NUM_WORDS stores data into shadow bits [a*WORD_WIDTH +: WORD_WIDTH], visible from the next cycle.
REQ-017 Bits of the last word beyond CONFIG_MEMORY_SIZE are discarded on write and read back as 0.
REQ-018 A written-word bitmap sets bit a on each in-range write; complete = all NUM_WORDS bits set.
REQ-019 States: EMPTY (no committed config), LOAD (shadow being written, bitmap not complete), READY (bitmap complete), ACTIVE (committed, no writes since).
REQ-020 Transitions: in-range write from EMPTY/ACTIVE -> LOAD; LOAD -> READY when the bitmap becomes complete; READY + commit -> ACTIVE; write in READY stays READY.
REQ-021 Commit in READY: config_memory <= shadow (pre-write contents of that cycle), bitmap cleared, config_valid = 1 from the next cycle onward.
REQ-022 Commit in EMPTY/LOAD: ignored, config_err pulses next cycle; commit in ACTIVE: no-op, no error.
REQ-023 Write with addr >= NUM_WORDS: ignored, state unchanged, config_err pulses next cycle.
REQ-024 Write and commit in the same cycle in READY: the commit uses the old shadow; the write lands in shadow and bitmap bit a is set after clear; state -> LOAD.
REQ-025 config_memory changes only on accepted commit; never partially updated.
REQ-026 Read: config_rd_data = shadow word at addr, config_rd_valid = 1, exactly one cycle after config_read; out-of-range read returns 0 with rd_valid = 1 and config_err pulse.
REQ-027 Read and write to the same address in the same cycle return the pre-write value.
REQ-028 config_err is the OR of all error causes in a cycle; one pulse per offending cycle.

Reset
REQ-029 rst clears shadow, bitmap, config_memory, config_rd_data, config_rd_valid, config_err and config_valid to 0; state -> EMPTY.
REQ-030 rst mid-load discards the partial shadow; the strobes in the rst cycle are ignored.

Configuration
REQ-031 Macro LAKE_CFG_READBACK_EN: when defined, REQ-026/027 apply.
REQ-032 When it is not defined: config_read is ignored, config_rd_data and config_rd_valid are tied to 0, and no read-path errors are raised.

Structure
REQ-033 Package lake_cfg_pkg holds WORD_WIDTH default, the state enum (EMPTY, LOAD, READY, ACTIVE) and the NUM_WORDS ceil-divide function.
REQ-034 One sub-module, lake_cfg_addr_decode, performs range check and one-hot word select, shared by the write and read paths.

Verification
REQ-035 Default parameters: write words 0..15 with data 0x1000+i, then commit -> config_valid=1 next cycle, config_memory[31:0]=0x1000, [511:480]=0x100F.
REQ-036 Write words 0..14 only, then commit -> config_err pulse, config_valid stays 0, config_memory stays 0.
REQ-037 Write addr 16 with 0xDEAD -> config_err pulse; readback of words 0..15 unchanged.
REQ-038 CONFIG_MEMORY_SIZE=500: write word 15 = 0xFFFFFFFF, read word 15 -> 0x000FFFFF one cycle later (LAKE_CFG_READBACK_EN defined).
REQ-039 After an ACTIVE load, in READY issue commit together with write of word 3 = 0xBEEF -> config_memory word 3 keeps its old value; state LOAD; readback of word 3 = 0xBEEF.
REQ-040 Assert rst after 8 writes -> all outputs 0, state EMPTY; the following commit produces config_err.
